rx_serial_word: RTL and testbench

Parametrised asynchronous serial receiver that assembles multi-byte words, LSB byte first, for the measurement and config channels. It generalises the fixed 8-bit, odd-parity, two-byte receivers. Baud divisor, data width, parity mode and bytes per word are configurable. It adds a synchroniser, start-bit glitch rejection, a word-level valid/ack handshake with overrun detection, and an optional inter-byte timeout. One instance sits per serial input (rx_serial_medida, rx_serial_config) in front of the config manager and temperature logic.

---
 rtl/tusca_rx_pkg.sv | 19 +
 rtl/rx_serial_frame.sv | 145 ++++++++++++++
 rtl/rx_serial_word.sv | 177 +++++++++++++++++
 tb/tb_rx_serial_word.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tusca_rx_pkg.sv
// Shared definitions for the serial word receivers.
// Contents:
//   PARITY_NONE / PARITY_EVEN / PARITY_ODD : values for the PARITY_MODE parameter
//   rx_state_e                             : bit-level FSM states, also exported on db_estado
package tusca_rx_pkg;

   localparam int unsigned PARITY_NONE = 0;
   localparam int unsigned PARITY_EVEN = 1;
   localparam int unsigned PARITY_ODD  = 2;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_e;

endpackage

// File: rtl/rx_serial_frame.sv
// Single byte-frame receiver: 2-flop synchroniser plus bit-level FSM.
// A frame is start bit, DATA_BITS data bits (LSB first), optional parity bit and one stop bit.
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   rx_serial    in   raw serial line, idle high
//   data_byte    out  received data bits, valid while byte_ok / error pulses are high
//   byte_ok      out  one-cycle pulse: stop = 1 and parity good
//   parity_error out  one-cycle pulse: parity bit mismatch
//   frame_error  out  one-cycle pulse: stop bit sampled as 0
//   estado       out  current FSM state
// The three pulses are combinational and coincide with the stop-bit sampling cycle.
module rx_serial_frame
   import tusca_rx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 5208,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY_MODE  = PARITY_ODD
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 rx_serial,
   output logic [DATA_BITS-1:0] data_byte,
   output logic                 byte_ok,
   output logic                 parity_error,
   output logic                 frame_error,
   output logic [2:0]           estado
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned IDX_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   logic [1:0]           sync_q;
   logic                 rx_s;
   rx_state_e            state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 bit_tick;
   logic                 stop_sample;
   logic                 par_expected;
   logic                 par_bad;

   assign rx_s     = sync_q[1];
   assign bit_tick = (cnt_q == CNT_LAST);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
      par_d       = par_q;
      stop_sample = 1'b0;
      case (state_q)
         IDLE: begin
            if (!rx_s) begin
               cnt_d   = '0;
               state_d = START;
            end
         end
         START: begin
            // Mid start bit: a line back at 1 here was only a glitch.
            if (cnt_q == CNT_HALF) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = rx_s ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (bit_tick) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
               if (idx_q == IDX_LAST) begin
                  state_d = (PARITY_MODE == PARITY_NONE) ? STOP : PARITY;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PARITY: begin
            if (bit_tick) begin
               cnt_d   = '0;
               par_d   = rx_s;
               state_d = STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STOP: begin
            // Leave at mid stop bit so a following start edge is never missed.
            if (bit_tick) begin
               cnt_d       = '0;
               stop_sample = 1'b1;
               state_d     = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      par_expected = par_q;
      if (PARITY_MODE == PARITY_EVEN) begin
         par_expected = ^shift_q;
      end else if (PARITY_MODE == PARITY_ODD) begin
         par_expected = ~^shift_q;
      end
      par_bad = (PARITY_MODE != PARITY_NONE) && (par_q != par_expected);
   end

   assign data_byte    = shift_q;
   assign byte_ok      = stop_sample && rx_s && !par_bad;
   assign parity_error = stop_sample && par_bad;
   assign frame_error  = stop_sample && !rx_s;
   assign estado       = state_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_q  <= 2'b11;
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], rx_serial};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         par_q   <= par_d;
      end
   end

endmodule

// File: rtl/rx_serial_word.sv
// Serial word receiver: assembles BYTES_PER_WORD byte-frames (first byte in the low bits) into
// a word held under a valid/ack handshake, with sticky overrun detection.
// Optional feature macro: RX_TIMEOUT_EN -- when defined, a partial word left idle for
// TIMEOUT_BITS bit times is discarded and timeout pulses; otherwise timeout is tied to 0.
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   rx_serial    in   serial line, idle high
//   word_ack     in   consumer has taken the held word
//   word_data    out  assembled word
//   word_valid   out  level, word_data holds an unacknowledged word
//   parity_error out  one-cycle pulse
//   frame_error  out  one-cycle pulse
//   overrun      out  sticky, a word completed while word_valid was set
//   timeout      out  one-cycle pulse, partial word discarded
//   db_estado    out  bit-FSM state for debug
module rx_serial_word
   import tusca_rx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT   = 5208,
   parameter int unsigned DATA_BITS      = 8,
   parameter int unsigned PARITY_MODE    = PARITY_ODD,
   parameter int unsigned BYTES_PER_WORD = 2,
   parameter int unsigned TIMEOUT_BITS   = 20
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic                                rx_serial,
   input  logic                                word_ack,
   output logic [BYTES_PER_WORD*DATA_BITS-1:0] word_data,
   output logic                                word_valid,
   output logic                                parity_error,
   output logic                                frame_error,
   output logic                                overrun,
   output logic                                timeout,
   output logic [2:0]                          db_estado
);

   localparam int unsigned WORD_W = BYTES_PER_WORD * DATA_BITS;
   localparam int unsigned BIDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
   localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(BYTES_PER_WORD - 1);

   if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY_MODE > PARITY_ODD ||
       BYTES_PER_WORD < 1 || BYTES_PER_WORD > 4 || TIMEOUT_BITS < 1) begin : g_param_check
      $error("rx_serial_word: illegal parameter value");
   end

   logic [DATA_BITS-1:0] f_byte;
   logic                 f_byte_ok;
   logic                 f_perr;
   logic                 f_ferr;
   logic [2:0]           f_state;

   logic [WORD_W-1:0] asm_q, asm_d;
   logic [WORD_W-1:0] merged;
   logic [BIDX_W-1:0] bidx_q, bidx_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic              valid_q, valid_d;
   logic              ovr_q, ovr_d;
   logic              perr_q, ferr_q;
   logic              tmo_fire;

   rx_serial_frame #(
      .CLKS_PER_BIT(CLKS_PER_BIT),
      .DATA_BITS   (DATA_BITS),
      .PARITY_MODE (PARITY_MODE)
   ) u_frame (
      .clock       (clock),
      .reset       (reset),
      .rx_serial   (rx_serial),
      .data_byte   (f_byte),
      .byte_ok     (f_byte_ok),
      .parity_error(f_perr),
      .frame_error (f_ferr),
      .estado      (f_state)
   );

`ifdef RX_TIMEOUT_EN
   localparam int unsigned TMO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int unsigned TMO_W      = $clog2(TMO_CYCLES);

   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             tmo_pulse_q;

   // Counts only while waiting between bytes of a partial word; leaving IDLE clears it.
   always_comb begin
      tmo_cnt_d = '0;
      tmo_fire  = 1'b0;
      if (f_state == IDLE && bidx_q != '0) begin
         if (tmo_cnt_q == TMO_W'(TMO_CYCLES - 1)) begin
            tmo_fire = 1'b1;
         end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tmo_cnt_q   <= '0;
         tmo_pulse_q <= 1'b0;
      end else begin
         tmo_cnt_q   <= tmo_cnt_d;
         tmo_pulse_q <= tmo_fire;
      end
   end

   assign timeout = tmo_pulse_q;
`else
   assign tmo_fire = 1'b0;
   assign timeout  = 1'b0;
`endif

   always_comb begin
      asm_d   = asm_q;
      bidx_d  = bidx_q;
      word_d  = word_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;

      merged = asm_q;
      merged[bidx_q*DATA_BITS +: DATA_BITS] = f_byte;

      if (word_ack && valid_q) begin
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end

      if (f_perr || f_ferr) begin
         bidx_d = '0;
      end else if (f_byte_ok) begin
         if (bidx_q == BIDX_LAST) begin
            bidx_d = '0;
            // A same-cycle ack frees the holding register, so the new word is taken.
            if (!valid_q || word_ack) begin
               word_d  = merged;
               valid_d = 1'b1;
            end else begin
               ovr_d = 1'b1;
            end
         end else begin
            asm_d  = merged;
            bidx_d = bidx_q + 1'b1;
         end
      end else if (tmo_fire) begin
         bidx_d = '0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         asm_q   <= '0;
         bidx_q  <= '0;
         word_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         asm_q   <= asm_d;
         bidx_q  <= bidx_d;
         word_q  <= word_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
         perr_q  <= f_perr;
         ferr_q  <= f_ferr;
      end
   end

   assign word_data    = word_q;
   assign word_valid   = valid_q;
   assign overrun      = ovr_q;
   assign parity_error = perr_q;
   assign frame_error  = ferr_q;
   assign db_estado    = f_state;

endmodule

// File: tb/tb_rx_serial_word.sv
// Directed bench for rx_serial_word: 16 clocks per bit, 8 data bits, odd parity, 2 bytes/word.
module tb_rx_serial_word;

   localparam int unsigned CPB = 16;

   logic        clock      = 1'b0;
   logic        reset      = 1'b0;
   logic        rx_serial  = 1'b1;
   logic        word_ack   = 1'b0;
   logic [15:0] word_data;
   logic        word_valid;
   logic        parity_error;
   logic        frame_error;
   logic        overrun;
   logic        timeout;
   logic [2:0]  db_estado;

   int n_tests = 0;
   int n_fail  = 0;

   // Values captured around the stop-bit sample of the last frame sent.
   logic        cap_wv_pre, cap_wv, cap_perr, cap_ferr, cap_ovr;
   logic        cap_perr_after, cap_ferr_after;
   logic [15:0] cap_data;

   rx_serial_word #(
      .CLKS_PER_BIT  (CPB),
      .DATA_BITS     (8),
      .PARITY_MODE   (2),
      .BYTES_PER_WORD(2),
      .TIMEOUT_BITS  (20)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .rx_serial   (rx_serial),
      .word_ack    (word_ack),
      .word_data   (word_data),
      .word_valid  (word_valid),
      .parity_error(parity_error),
      .frame_error (frame_error),
      .overrun     (overrun),
      .timeout     (timeout),
      .db_estado   (db_estado)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_bits(input int n);
      rx_serial = 1'b1;
      repeat (n * CPB) tick();
   endtask

   // Frame starts right after a clock edge; the DUT samples the stop bit on the 11th edge
   // of the stop-bit period (2 sync + 1 detect + 8 half-bit + 10*16 cycles from the start).
   task automatic send_frame(input logic [7:0] d, input logic flip_par, input logic stop_bit,
                             input logic ack_at_stop);
      logic [10:0] bits;
      bits = {stop_bit, (~^d) ^ flip_par, d, 1'b0};
      for (int b = 0; b < 10; b++) begin
         rx_serial = bits[b];
         repeat (CPB) tick();
      end
      rx_serial = bits[10];
      for (int j = 0; j < CPB; j++) begin
         if (j == 10) begin
            cap_wv_pre = word_valid;
            if (ack_at_stop) word_ack = 1'b1;
         end
         tick();
         if (j == 10) begin
            word_ack = 1'b0;
            cap_wv   = word_valid;
            cap_data = word_data;
            cap_perr = parity_error;
            cap_ferr = frame_error;
            cap_ovr  = overrun;
         end
         if (j == 11) begin
            cap_perr_after = parity_error;
            cap_ferr_after = frame_error;
         end
      end
   endtask

   task automatic send_good(input logic [7:0] d);
      send_frame(d, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic do_ack();
      word_ack = 1'b1;
      tick();
      word_ack = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) tick();
      n_tests++;
      if ({word_valid, parity_error, frame_error, overrun, timeout} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b want 00000",
                  {word_valid, parity_error, frame_error, overrun, timeout});
      end
      n_tests++;
      if (word_data !== 16'h0000 || db_estado !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_state: data %h st %0d want 0000 st 0", word_data, db_estado);
      end
      reset = 1'b1;
      repeat (4) tick();
      send_good(8'h55);
      rx_serial = 1'b0;
      repeat (3 * CPB) tick();
      n_tests++;
      if (db_estado !== 3'd2) begin
         n_fail++;
         $display("FAIL midframe_state: got %0d want 2", db_estado);
      end
      #1 reset = 1'b0;
      #1;
      n_tests++;
      if (db_estado !== 3'd0 || word_valid !== 1'b0 || word_data !== 16'h0000) begin
         n_fail++;
         $display("FAIL async_reset: st %0d valid %b data %h want 0 0 0000",
                  db_estado, word_valid, word_data);
      end
      rx_serial = 1'b1;
      repeat (3) tick();
      reset = 1'b1;
      idle_bits(2);
   endtask

   task automatic test_word();
      send_good(8'h02);
      n_tests++;
      if (cap_wv !== 1'b0) begin
         n_fail++;
         $display("FAIL half_word_valid: got %b want 0", cap_wv);
      end
      send_good(8'h22);
      n_tests++;
      if (cap_wv_pre !== 1'b0 || cap_wv !== 1'b1) begin
         n_fail++;
         $display("FAIL valid_timing: pre %b post %b want 0 1", cap_wv_pre, cap_wv);
      end
      n_tests++;
      if (cap_data !== 16'h2202) begin
         n_fail++;
         $display("FAIL word_2202: got %h want 2202", cap_data);
      end
      idle_bits(3);
      n_tests++;
      if (word_valid !== 1'b1 || word_data !== 16'h2202) begin
         n_fail++;
         $display("FAIL valid_hold: valid %b data %h want 1 2202", word_valid, word_data);
      end
      do_ack();
      n_tests++;
      if (word_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL ack_clear: got %b want 0", word_valid);
      end
      do_ack();
      n_tests++;
      if (word_valid !== 1'b0 || overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_ack: valid %b ovr %b want 0 0", word_valid, overrun);
      end
   endtask

   task automatic test_parity();
      send_good(8'h56);
      send_frame(8'h34, 1'b1, 1'b1, 1'b0);
      n_tests++;
      if (cap_perr !== 1'b1 || cap_ferr !== 1'b0 || cap_perr_after !== 1'b0) begin
         n_fail++;
         $display("FAIL parity_pulse: perr %b ferr %b next %b want 1 0 0",
                  cap_perr, cap_ferr, cap_perr_after);
      end
      n_tests++;
      if (cap_wv !== 1'b0) begin
         n_fail++;
         $display("FAIL parity_no_word: got %b want 0", cap_wv);
      end
      send_good(8'h34);
      send_good(8'h12);
      n_tests++;
      if (cap_wv !== 1'b1 || cap_data !== 16'h1234) begin
         n_fail++;
         $display("FAIL word_1234: valid %b data %h want 1 1234", cap_wv, cap_data);
      end
      do_ack();
   endtask

   task automatic test_frame();
      send_good(8'hAA);
      send_frame(8'h77, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (cap_ferr !== 1'b1 || cap_perr !== 1'b0 || cap_ferr_after !== 1'b0) begin
         n_fail++;
         $display("FAIL frame_pulse: ferr %b perr %b next %b want 1 0 0",
                  cap_ferr, cap_perr, cap_ferr_after);
      end
      idle_bits(2);
      send_good(8'h00);
      send_good(8'h10);
      n_tests++;
      if (cap_wv !== 1'b1 || cap_data !== 16'h1000) begin
         n_fail++;
         $display("FAIL word_1000: valid %b data %h want 1 1000", cap_wv, cap_data);
      end
      do_ack();
   endtask

   task automatic test_overrun();
      send_good(8'h01);
      send_good(8'h20);
      send_good(8'h02);
      send_good(8'h30);
      n_tests++;
      if (cap_wv !== 1'b1 || cap_data !== 16'h2001 || cap_ovr !== 1'b1) begin
         n_fail++;
         $display("FAIL overrun_set: valid %b data %h ovr %b want 1 2001 1",
                  cap_wv, cap_data, cap_ovr);
      end
      do_ack();
      n_tests++;
      if (word_valid !== 1'b0 || overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL overrun_ack: valid %b ovr %b want 0 0", word_valid, overrun);
      end
   endtask

   task automatic test_back_to_back_ack();
      send_good(8'h11);
      send_good(8'h22);
      send_good(8'h33);
      send_frame(8'h44, 1'b0, 1'b1, 1'b1);
      n_tests++;
      if (cap_wv_pre !== 1'b1 || cap_wv !== 1'b1 || cap_data !== 16'h4433 || cap_ovr !== 1'b0) begin
         n_fail++;
         $display("FAIL ack_collide: pre %b valid %b data %h ovr %b want 1 1 4433 0",
                  cap_wv_pre, cap_wv, cap_data, cap_ovr);
      end
      do_ack();
   endtask

   task automatic test_glitch();
      logic seen_err;
      seen_err  = 1'b0;
      rx_serial = 1'b0;
      repeat (CPB / 4) tick();
      n_tests++;
      if (db_estado !== 3'd1) begin
         n_fail++;
         $display("FAIL glitch_start: got %0d want 1", db_estado);
      end
      rx_serial = 1'b1;
      repeat (40) begin
         tick();
         seen_err = seen_err | parity_error | frame_error;
      end
      n_tests++;
      if (db_estado !== 3'd0 || seen_err !== 1'b0 || word_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL glitch_reject: st %0d err %b valid %b want 0 0 0",
                  db_estado, seen_err, word_valid);
      end
      send_good(8'h5A);
      send_good(8'hA5);
      n_tests++;
      if (cap_wv !== 1'b1 || cap_data !== 16'hA55A) begin
         n_fail++;
         $display("FAIL word_a55a: valid %b data %h want 1 a55a", cap_wv, cap_data);
      end
      do_ack();
   endtask

   task automatic test_timeout();
      int pulses;
      int first_at;
      pulses   = 0;
      first_at = -1;
      send_good(8'h77);
      for (int i = 1; i <= 20 * CPB + 64; i++) begin
         tick();
         if (timeout === 1'b1) begin
            pulses++;
            if (first_at < 0) first_at = i;
         end
      end
`ifdef RX_TIMEOUT_EN
      n_tests++;
      if (pulses != 1 || first_at < 20 * CPB - 32 || first_at > 20 * CPB + 16) begin
         n_fail++;
         $display("FAIL timeout_pulse: count %0d at %0d want 1 near %0d",
                  pulses, first_at, 20 * CPB);
      end
      send_good(8'h02);
      send_good(8'h22);
      n_tests++;
      if (cap_wv !== 1'b1 || cap_data !== 16'h2202) begin
         n_fail++;
         $display("FAIL timeout_fresh: valid %b data %h want 1 2202", cap_wv, cap_data);
      end
`else
      n_tests++;
      if (pulses != 0) begin
         n_fail++;
         $display("FAIL timeout_off: count %0d want 0", pulses);
      end
      send_good(8'h22);
      n_tests++;
      if (cap_wv !== 1'b1 || cap_data !== 16'h2277) begin
         n_fail++;
         $display("FAIL partial_kept: valid %b data %h want 1 2277", cap_wv, cap_data);
      end
`endif
      do_ack();
   endtask

   initial begin
      test_reset();
      test_word();
      test_parity();
      test_frame();
      test_overrun();
      test_back_to_back_ack();
      test_glitch();
      test_timeout();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
